// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - shared types and index helpers for the collision matrix
package collision_pkg;

  typedef enum logic {WAIT_SOF, COLLECT} stateT;

  // Flat bit position of pair (A[i], B[j]) in the pair vectors.
  function automatic int pair_idx(input int i, input int j, input int numB);
    return i * numB + j;
  endfunction

  function automatic int bidx_w(input int numB);
    return (numB > 1) ? $clog2(numB) : 1;
  endfunction

endpackage

// File: rtl/collision_pair_tracker.sv
// rtl/collision_pair_tracker.sv - per-pair hit latch, hold-off counter and report pulse
module collision_pair_tracker #(
  parameter int HOLDOFF_FRAMES = 0
) (
  input  logic clk,
  input  logic resetN,
  input  logic collect,
  input  logic sof,
  input  logic hit,
  output logic report,
  output logic holdZero,
  output logic hitPulse
);

  localparam int CW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

  logic [CW-1:0] holdCnt;
  logic          hitLatch;

  assign holdZero = (holdCnt == '0);
  // A hit in the boundary cycle itself still belongs to the frame being closed.
  assign report   = (hitLatch | hit) & holdZero;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      holdCnt  <= '0;
      hitLatch <= 1'b0;
      hitPulse <= 1'b0;
    end else begin
      hitPulse <= 1'b0;
      if (!collect) begin
        hitLatch <= 1'b0;
      end else if (sof) begin
        hitPulse <= report;
        hitLatch <= 1'b0;
        if (report)
          holdCnt <= CW'(HOLDOFF_FRAMES);
        else if (!holdZero)
          holdCnt <= holdCnt - CW'(1);
      end else if (hit) begin
        hitLatch <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/collision_matrix.sv
// rtl/collision_matrix.sv - per-frame A/B pixel collision detector with first-hit capture
module collision_matrix
  import collision_pkg::*;
#(
  parameter int NUM_A          = 2,
  parameter int NUM_B          = 4,
  parameter int X_W            = 11,
  parameter int Y_W            = 11,
  parameter int HOLDOFF_FRAMES = 0,
  localparam int BIDX_W        = bidx_w(NUM_B)
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic [X_W-1:0]            pixelX,
  input  logic [Y_W-1:0]            pixelY,
  input  logic [NUM_A-1:0]          reqA,
  input  logic [NUM_B-1:0]          reqB,
  input  logic [NUM_A*NUM_B-1:0]    pairEnable,
  output logic [NUM_A*NUM_B-1:0]    hitPulse,
  output logic [NUM_A-1:0]          hitValid,
  output logic [NUM_A*X_W-1:0]      hitX,
  output logic [NUM_A*Y_W-1:0]      hitY,
  output logic [NUM_A*BIDX_W-1:0]   hitBIdx
);

  stateT                          state;
  logic [NUM_A*NUM_B-1:0]         hitFlat;
  logic [NUM_A*NUM_B-1:0]         reportFlat;
  logic [NUM_A*NUM_B-1:0]         holdZeroFlat;
  logic [NUM_A-1:0]               candAny;
  logic [NUM_A-1:0][BIDX_W-1:0]   candIdx;
  logic [NUM_A-1:0]               reportAny;
  logic [NUM_A-1:0]               fhValid;
  logic [NUM_A-1:0][X_W-1:0]      fhX;
  logic [NUM_A-1:0][Y_W-1:0]      fhY;
  logic [NUM_A-1:0][BIDX_W-1:0]   fhB;

  for (genvar i = 0; i < NUM_A; i++) begin : gA
    for (genvar j = 0; j < NUM_B; j++) begin : gB
      localparam int P = pair_idx(i, j, NUM_B);
      assign hitFlat[P] = reqA[i] & reqB[j] & pairEnable[P];
      collision_pair_tracker #(.HOLDOFF_FRAMES(HOLDOFF_FRAMES)) uTracker (
        .clk      (clk),
        .resetN   (resetN),
        .collect  (state == COLLECT),
        .sof      (startOfFrame),
        .hit      (hitFlat[P]),
        .report   (reportFlat[P]),
        .holdZero (holdZeroFlat[P]),
        .hitPulse (hitPulse[P])
      );
    end
  end

  // Descending scan so the lowest hitting B index wins.
  always_comb begin
    candAny   = '0;
    candIdx   = '0;
    reportAny = '0;
    for (int i = 0; i < NUM_A; i++) begin
      for (int j = NUM_B - 1; j >= 0; j--) begin
        if (hitFlat[pair_idx(i, j, NUM_B)] && holdZeroFlat[pair_idx(i, j, NUM_B)]) begin
          candAny[i] = 1'b1;
          candIdx[i] = BIDX_W'(j);
        end
        reportAny[i] = reportAny[i] | reportFlat[pair_idx(i, j, NUM_B)];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= WAIT_SOF;
      fhValid  <= '0;
      fhX      <= '0;
      fhY      <= '0;
      fhB      <= '0;
      hitValid <= '0;
      hitX     <= '0;
      hitY     <= '0;
      hitBIdx  <= '0;
    end else begin
      case (state)
        WAIT_SOF: if (startOfFrame) state <= COLLECT;
        COLLECT: begin
          if (startOfFrame) begin
            hitValid <= reportAny;
            for (int i = 0; i < NUM_A; i++) begin
              hitX[i*X_W +: X_W]          <= '0;
              hitY[i*Y_W +: Y_W]          <= '0;
              hitBIdx[i*BIDX_W +: BIDX_W] <= '0;
              if (reportAny[i]) begin
                // No earlier capture means the first hit is in this very cycle.
                hitX[i*X_W +: X_W]          <= fhValid[i] ? fhX[i] : pixelX;
                hitY[i*Y_W +: Y_W]          <= fhValid[i] ? fhY[i] : pixelY;
                hitBIdx[i*BIDX_W +: BIDX_W] <= fhValid[i] ? fhB[i] : candIdx[i];
              end
            end
            fhValid <= '0;
            fhX     <= '0;
            fhY     <= '0;
            fhB     <= '0;
          end else begin
            for (int i = 0; i < NUM_A; i++) begin
              if (!fhValid[i] && candAny[i]) begin
                fhValid[i] <= 1'b1;
                fhX[i]     <= pixelX;
                fhY[i]     <= pixelY;
                fhB[i]     <= candIdx[i];
              end
            end
          end
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: doc/collision_matrix.md
Name: collision_matrix

Overview:
- Parametrised pixel-level collision detector between two groups of drawn objects: group A (players/arrows) and group B (bubbles/bonuses).
- Each clock it checks the per-pixel draw requests of both groups and records any overlap, per A/B pair, over the current frame.
- Once per frame, at startOfFrame, it reports the recorded pairs as single-cycle pulses, together with the first-hit pixel per A channel.
- A per-pair frame hold-off suppresses repeated reports (e.g. invulnerability after a life is lost).
- Sits between the object drawers and the game/movement controllers.

Parameters:
- NUM_A, 2, number of group-A objects.
- NUM_B, 4, number of group-B objects.
- X_W, 11, pixel X width.
- Y_W, 11, pixel Y width.
- HOLDOFF_FRAMES, 0, frames a pair stays suppressed after it reports (0 = no hold-off).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle frame-boundary strobe, asserted during blanking.
- pixelX  in  X_W  current pixel X.
- pixelY  in  Y_W  current pixel Y.
- reqA  in  NUM_A  group-A draw requests.
- reqB  in  NUM_B  group-B draw requests.
- pairEnable  in  NUM_A*NUM_B  per-pair enable mask; bit i*NUM_B+j enables pair (A[i], B[j]).
- hitPulse  out  NUM_A*NUM_B  per-pair one-cycle collision report; same bit mapping as pairEnable.
- hitValid  out  NUM_A  A[i] had at least one reported collision in the last frame.
- hitX  out  NUM_A*X_W  first-hit X per A channel.
- hitY  out  NUM_A*Y_W  first-hit Y per A channel.
- hitBIdx  out  NUM_A*$clog2(NUM_B)  B index of the first hit per A channel.

Behaviour:
- Pair hit condition, combinational: hit[i][j] = reqA[i] & reqB[j] & pairEnable[i*NUM_B+j].
- State machine, states WAIT_SOF and COLLECT:
  - Reset enters WAIT_SOF.
  - WAIT_SOF ignores all hits, so a partial frame is never reported.
  - The first startOfFrame moves to COLLECT and produces no pulses.
  - COLLECT persists; every later startOfFrame is a report boundary.
- Reset values: all outputs 0, latches 0, first-hit registers 0, hold-off counters 0.
- Reset mid-frame discards all accumulated state and returns to WAIT_SOF.
- In COLLECT:
  - hitLatch[i][j] sets on any cycle where hit[i][j] is true.
  - First-hit capture: on the first cycle of the frame where any enabled pair of A[i] hits, record pixelX/pixelY and the lowest j that hits. Later hits in the same frame do not overwrite it.
- Report at a startOfFrame in cycle t (COLLECT state). In cycle t+1:
  - hitPulse[p] = (hitLatch[p] | hit[p] sampled in cycle t) & (holdCnt[p] == 0).
  - hitValid[i] = OR over j of the reported hitPulse bits for A[i]; hitX/hitY/hitBIdx present the captured first hit.
  - hitPulse is high for exactly one cycle.
  - hitValid/hitX/hitY/hitBIdx hold until the next report.
  - If hitValid[i] is 0, hitX/hitY/hitBIdx[i] read 0.
- Latches and first-hit capture clear in cycle t+1, so hits from cycle t+1 onward belong to the new frame.
- Hold-off:
  - When hitPulse[p] fires, holdCnt[p] loads HOLDOFF_FRAMES.
  - Otherwise holdCnt[p] decrements by 1 at each startOfFrame while nonzero.
  - Counter width is $clog2(HOLDOFF_FRAMES+1), minimum 1.
  - A suppressed pair still clears its latch and contributes nothing to hitValid/first-hit.
- First-hit capture only considers pairs with holdCnt == 0.
- Reporting latency: one cycle after startOfFrame.
- Multiple B hits in the same pixel/cycle: the lowest index wins for hitBIdx; all hit bits latch.
- pairEnable is sampled per cycle; deasserting it mid-frame does not clear already-latched bits.
- Back-to-back startOfFrame strobes are legal; an empty frame reports all zeros.

Decomposition:
- Package collision_pkg holds:
  - pair-index function pair_idx(i, j) = i*NUM_B + j;
  - BIDX_W = $clog2(NUM_B) with a minimum of 1;
  - the state enum {WAIT_SOF, COLLECT}.
- Sub-module collision_pair_tracker, one instance per pair via generate: hit latch, hold-off counter and pulse register.
- Top level keeps the FSM, first-hit capture and priority encoder.

Test Plan:
- Reset, then reqA[0]=1 and reqB[2]=1 in the same cycle before the first startOfFrame, then SOF -> no hitPulse, hitValid=0.
- Defaults, after the first SOF: reqA[0]&reqB[1] at (100,200), then again at (105,210), then SOF -> hitPulse bit 1 high for exactly one cycle at SOF+1; hitX[0]=100, hitY[0]=200, hitBIdx[0]=1, hitValid[0]=1.
- reqA[1] with reqB[0] and reqB[3] simultaneously at (50,60), pairEnable bit 7 = 0 -> only bit 4 pulses; hitBIdx[1]=0.
- HOLDOFF_FRAMES=2, pair (0,0) colliding every frame -> pulses in frames n, n+3, n+6; no pulse in the frames between.
- resetN asserted mid-frame after a hit, then released, then two SOFs with no hits -> all outputs stay 0.
- Hit only during the SOF cycle itself -> reported at SOF+1; a hit at SOF+1 is reported at the following SOF.
